// File: rtl/udp_tx_framer_if.sv
// UDP TX framer bus: FIFO read side plus EMAC client transmit side.
// master = the framer, slave = FIFO/EMAC environment.
interface udp_tx_framer_if;
    logic [15:0] udp_tx_pending_data;
    logic [7:0]  udp_tx;
    logic        udp_tx_rden;
    logic [7:0]  eth_tx_data;
    logic        eth_tx_data_en;
    logic        eth_tx_ack;

    modport master (
        input  udp_tx_pending_data, udp_tx, eth_tx_ack,
        output udp_tx_rden, eth_tx_data, eth_tx_data_en
    );

    modport slave (
        output udp_tx_pending_data, udp_tx, eth_tx_ack,
        input  udp_tx_rden, eth_tx_data, eth_tx_data_en
    );
endinterface

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: prefixes Ethernet II / IPv4 / UDP headers to a payload read
// from the UDP TX FIFO and streams the frame to the EMAC client TX port.
// Optional feature macro: UDP_TX_PAD_EN (pad short frames with zeros to 60 bytes).
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
    parameter logic [31:0] DST_IP      = 32'hC0A80101,
    parameter logic [15:0] SRC_PORT    = 16'h04D2,
    parameter logic [15:0] DST_PORT    = 16'h04D2,
    parameter logic [7:0]  TTL         = 8'h40,
    parameter int          MAX_PAYLOAD = 1472
) (
    input  logic             clk,
    input  logic             rst_n,
    udp_tx_framer_if.master  bus,
    output logic             busy
);
    localparam logic [15:0] MAXP = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE, CSUM1, CSUM2, WAIT_ACK, HDR, PAYLOAD
`ifdef UDP_TX_PAD_EN
        , PAD
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;     // index of the frame byte currently on eth_tx_data
    logic [15:0] len;              // payload length latched in IDLE
    logic [15:0] ip_id;
    logic [31:0] sum;
    logic [15:0] csum;
    logic [15:0] tot_len, udp_len, flen;
    logic [7:0]  data_nxt;
    logic        en_nxt, rden_nxt, frame_done;
    logic [31:0] sum_c, fold1, fold2;
    logic [9:0][15:0]  ip_w;
    logic [41:0][7:0]  hdr_p;      // hdr_p[41] is frame byte 0

    assign tot_len = len + 16'd28;
    assign udp_len = len + 16'd8;

`ifdef UDP_TX_PAD_EN
    assign flen = (len < 16'd18) ? 16'd60 : len + 16'd42;
`else
    assign flen = len + 16'd42;
`endif

    assign hdr_p = {DST_MAC, SRC_MAC, 16'h0800,
                    16'h4500, tot_len, ip_id, 16'h4000, TTL, 8'h11, csum,
                    SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, 16'h0000};

    // IPv4 header words with the checksum field taken as zero
    assign ip_w = {16'h4500, tot_len, ip_id, 16'h4000, {TTL, 8'h11}, 16'h0000,
                   SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]};

    // Raw 32-bit header sum and its two-stage carry fold
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < 10; i++) sum_c = sum_c + {16'd0, ip_w[i]};
        fold1 = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        fold2 = {16'd0, fold1[15:0]} + {16'd0, fold1[31:16]};
    end

    // Next state and next (registered) output values
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        data_nxt   = 8'h00;
        en_nxt     = 1'b0;
        rden_nxt   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:     if (bus.udp_tx_pending_data != 16'd0) state_nxt = CSUM1;
            CSUM1:    state_nxt = CSUM2;
            CSUM2: begin
                state_nxt = WAIT_ACK;
                cnt_nxt   = 16'd0;
                en_nxt    = 1'b1;
                data_nxt  = hdr_p[41];
            end
            WAIT_ACK: begin
                en_nxt   = 1'b1;
                data_nxt = hdr_p[41];
                if (bus.eth_tx_ack) begin
                    state_nxt = HDR;
                    cnt_nxt   = 16'd1;
                    data_nxt  = hdr_p[40];
                end
            end
            HDR, PAYLOAD
`ifdef UDP_TX_PAD_EN
            , PAD
`endif
            : begin
                if (cnt == flen - 16'd1) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = 16'd0;
                    frame_done = 1'b1;
                end else begin
                    cnt_nxt  = cnt + 16'd1;
                    en_nxt   = 1'b1;
                    // FIFO data lags the strobe by one cycle, so reads lead
                    // the payload window by two byte slots
                    rden_nxt = (cnt_nxt >= 16'd40) && (cnt_nxt < len + 16'd40);
                    if (cnt_nxt < 16'd42) begin
                        state_nxt = HDR;
                        data_nxt  = hdr_p[6'd41 - cnt_nxt[5:0]];
                    end else if (cnt_nxt < len + 16'd42) begin
                        state_nxt = PAYLOAD;
                        data_nxt  = bus.udp_tx;
                    end else begin
`ifdef UDP_TX_PAD_EN
                        state_nxt = PAD;
`else
                        state_nxt = PAYLOAD;
`endif
                        data_nxt  = 8'h00;
                    end
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // State, byte counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            bus.eth_tx_data    <= 8'h00;
            bus.eth_tx_data_en <= 1'b0;
            bus.udp_tx_rden    <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            bus.eth_tx_data    <= data_nxt;
            bus.eth_tx_data_en <= en_nxt;
            bus.udp_tx_rden    <= rden_nxt;
            busy               <= (state_nxt != IDLE);
        end
    end

    // Length latch, checksum pipeline and per-frame IP identification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            sum   <= '0;
            csum  <= '0;
            ip_id <= '0;
        end else begin
            if (state == IDLE && bus.udp_tx_pending_data != 16'd0)
                len <= (bus.udp_tx_pending_data > MAXP) ? MAXP : bus.udp_tx_pending_data;
            if (state == CSUM1) sum  <= sum_c;
            if (state == CSUM2) csum <= ~fold2[15:0];
            if (frame_done)     ip_id <= ip_id + 16'd1;
        end
    end
endmodule
